lsu: RTL

Load/store stage of the 4-stage pipeline. Consumes the registered execute-stage bundle (ALU result, store data, load/store/writeback controls, destination register), performs data-memory accesses over a req/ack handshake, aligns and extends load data, and produces the registered writeback to the register file. It asserts a stall to the hazard unit while a memory access is outstanding.

---
 rtl/lsu.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store stage: issues data-memory accesses over req/ack, aligns and extends load data, registers the writeback.
// ALU ops write back one cycle after issue; memory ops hold stall from issue until the ack edge.
module lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] Rd2_exe2lsu,
  input  logic [1:0]       Memtoreg_exe2lsu,
  input  logic [2:0]       Ld_cntr_exe2lsu,
  input  logic [1:0]       St_cntr_exe2lsu,
  input  logic             RegW_exe2lsu,
  input  logic [4:0]       wr_addr_exe2lsu,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  output logic             stall,
  output logic             wb_en,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             misalign
);

  typedef enum logic {IDLE, WAIT} state_e;

  typedef struct packed {
    logic [2:0] ld_type;
    logic [1:0] off;
    logic [4:0] rd;
    logic       wr;
  } pend_t;

  state_e           state_q, state_d;
  pend_t            pend_q, pend_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             misalign_q, misalign_d;

  // Writeback source is implied by the op kind; Memtoreg carries no extra information here.
  logic unused_memtoreg;
  assign unused_memtoreg = ^Memtoreg_exe2lsu;

  logic             ld_valid, is_store, is_load, is_mem, aligned, rd_nonzero;
  logic [1:0]       acc_size;
  logic [1:0]       off;
  logic [3:0]       st_be;
  logic [WIDTH-1:0] st_wdata;

  always_comb begin
    off        = alu_result[1:0];
    ld_valid   = (Ld_cntr_exe2lsu != 3'd0) && (Ld_cntr_exe2lsu <= 3'd5);
    is_store   = (St_cntr_exe2lsu != 2'd0);
    is_load    = ld_valid && !is_store;
    is_mem     = ld_valid || is_store;
    rd_nonzero = (wr_addr_exe2lsu != 5'd0);
    // acc_size: 0 byte, 1 halfword, 2 word; the store type wins when both are set
    acc_size = 2'd0;
    if (is_store) begin
      acc_size = St_cntr_exe2lsu - 2'd1;
    end else begin
      case (Ld_cntr_exe2lsu)
        3'b010, 3'b101: acc_size = 2'd1;
        3'b011:         acc_size = 2'd2;
        default:        acc_size = 2'd0;
      endcase
    end
    case (acc_size)
      2'd1:    aligned = !off[0];
      2'd2:    aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    case (acc_size)
      2'd0: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{Rd2_exe2lsu[7:0]}};
      end
      2'd1: begin
        st_be    = 4'b0011 << off;
        st_wdata = {2{Rd2_exe2lsu[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = Rd2_exe2lsu;
      end
    endcase
  end

  // Halfwords are always 2-aligned, so a byte-granular shift serves both widths.
  logic [WIDTH-1:0] rd_shift;
  logic [WIDTH-1:0] ld_val;

  always_comb begin
    rd_shift = mem_rdata >> {pend_q.off, 3'b000};
    case (pend_q.ld_type)
      3'b001:  ld_val = {{(WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ld_val = {{(WIDTH-8){1'b0}}, rd_shift[7:0]};
      3'b010:  ld_val = {{(WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  ld_val = {{(WIDTH-16){1'b0}}, rd_shift[15:0]};
      default: ld_val = rd_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_en_d     = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (!is_mem) begin
          wb_en_d   = RegW_exe2lsu && rd_nonzero;
          wb_addr_d = wr_addr_exe2lsu;
          wb_data_d = alu_result;
        end else if (!aligned) begin
          misalign_d = 1'b1;
        end else begin
          state_d        = WAIT;
          mem_req_d      = 1'b1;
          mem_we_d       = is_store;
          mem_addr_d     = {alu_result[WIDTH-1:2], 2'b00};
          mem_be_d       = is_store ? st_be : 4'b1111;
          if (is_store) begin
            mem_wdata_d = st_wdata;
          end
          pend_d.ld_type = is_load ? Ld_cntr_exe2lsu : 3'b000;
          pend_d.off     = off;
          pend_d.rd      = wr_addr_exe2lsu;
          pend_d.wr      = is_load && RegW_exe2lsu && rd_nonzero;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (pend_q.wr) begin
            wb_en_d   = 1'b1;
            wb_addr_d = pend_q.rd;
            wb_data_d = ld_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign misalign  = misalign_q;
  assign stall     = (state_q == WAIT);

endmodule
